// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and LSU, D priority with a fetch anti-starvation streak limit; define MEM_ARB_MISALIGN_EN to reject misaligned D accesses locally
module mem_port_arbiter #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_width,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_width,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP, ERR} state_t;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
  state_t     state;
  logic       owner;
  logic [3:0] streak;
  logic       arb, d_win, d_mis, mis_go, resp;
  // winner selection at arbitration points and requester-facing strobes
  always_comb begin
    arb = !rst && (state == IDLE || (state == WAIT_RESP && m_rvalid));
    d_win = d_req && !(if_req && streak == STREAK_MAX);
`ifdef MEM_ARB_MISALIGN_EN
    d_mis = d_req && ((d_width == 2'b01 && d_addr[0]) || (d_width == 2'b10 && d_addr[1:0] != 2'b00));
    d_err = state == ERR;
`else
    d_mis = 1'b0;
    d_err = 1'b0;
`endif
    mis_go = arb && d_win && d_mis;
    resp = state == WAIT_RESP && m_rvalid;
    if_gnt = state == WAIT_GNT && m_gnt && !owner;
    d_gnt = (state == WAIT_GNT && m_gnt && owner) || mis_go;
    if_rvalid = resp && !owner;
    d_rvalid = (resp && owner) || state == ERR;
    if_rdata = if_rvalid ? m_rdata : '0;
    d_rdata = resp && owner ? m_rdata : '0;
    busy = state != IDLE;
  end
  // transaction sequencing; a D win only grows the streak while fetch is waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      streak <= '0;
      m_req <= 1'b0;
      m_addr <= '0;
      m_we <= 1'b0;
      m_wdata <= '0;
      m_width <= '0;
    end else if (arb && (if_req || d_req)) begin
      owner <= d_win;
      streak <= d_win && if_req ? streak + 4'd1 : '0;
      state <= mis_go ? ERR : WAIT_GNT;
      m_req <= !mis_go;
      m_addr <= d_win ? d_addr : if_addr;
      m_we <= d_win && d_we;
      m_wdata <= d_win ? d_wdata : '0;
      m_width <= d_win ? d_width : 2'b10;
    end else if (arb) begin
      state <= IDLE;
      m_req <= 1'b0;
    end else if (state == WAIT_GNT && m_gnt) begin
      state <= WAIT_RESP;
      m_req <= 1'b0;
    end else if (state == ERR) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of mem_port_arbiter against a transaction-level reference model
module tb_mem_port_arbiter;
  localparam int MAXD = 4;
  logic clk = 1'b0;
  logic rst;
  logic if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0] d_width;
  logic m_req, m_we, m_gnt, m_rvalid, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0] m_width;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DSTREAK(MAXD)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_width(d_width),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_width(m_width),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  typedef struct {
    logic        d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  width;
  } txn_t;

  txn_t if_q[$], d_q[$], exp_q[$];
  logic own_q[$], order_q[$];
  logic [31:0] rdata_q[$];
  int n_chk = 0, n_fail = 0;
  bit drv_en, mem_en, mon_en, rand_mode, rpend;
  int gdly, rdly, wcnt, rcnt;
  logic [31:0] rbuf;

  function automatic txn_t mk(logic d, logic [31:0] a, logic we, logic [31:0] wd, logic [1:0] w);
    txn_t t;
    t.d = d; t.addr = a; t.we = we; t.wdata = wd; t.width = w;
    return t;
  endfunction

  // expected grant order: D first, except IF wins once D has won MAXD times in a row while IF waited
  function automatic void build_order();
    int i = 0, j = 0, s = 0;
    while (i < if_q.size() || j < d_q.size()) begin
      if (j < d_q.size() && !(i < if_q.size() && s == MAXD)) begin
        exp_q.push_back(d_q[j]);
        s = i < if_q.size() ? s + 1 : 0;
        j++;
      end else begin
        exp_q.push_back(if_q[i]);
        s = 0;
        i++;
      end
    end
  endfunction

  task automatic mem_model();
    if (!mem_en) return;
    if (m_gnt) begin
      rpend = 1; rcnt = rdly; m_gnt = 0;
      rbuf = rdata_q.size() != 0 ? rdata_q.pop_front() : $urandom();
      if (rand_mode) begin gdly = $urandom_range(0, 3); rdly = $urandom_range(0, 2); end
    end
    m_rvalid = 0; m_rdata = 0;
    if (rpend) begin
      if (rcnt == 0) begin m_rvalid = 1; m_rdata = rbuf; rpend = 0; end
      else rcnt--;
    end else if (m_req) begin
      if (wcnt >= gdly) begin m_gnt = 1; wcnt = 0; end
      else wcnt++;
    end
  endtask

  task automatic monitor();
    txn_t e;
    logic o;
    if (!mon_en) return;
    if (m_req) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_mreq: m_addr=%h, no request expected", m_addr);
      end else begin
        e = exp_q[0];
        n_chk++;
        if ({m_addr, m_we, m_width} !== {e.addr, e.we, e.width} || (e.d && m_wdata !== e.wdata)) begin
          n_fail++;
          $display("FAIL m_fields: got addr=%h we=%b width=%b wdata=%h, want addr=%h we=%b width=%b wdata=%h",
                   m_addr, m_we, m_width, m_wdata, e.addr, e.we, e.width, e.wdata);
        end
        if (m_gnt) begin
          n_chk++;
          if ({if_gnt, d_gnt} !== {!e.d, e.d}) begin
            n_fail++;
            $display("FAIL gnt_route: got if_gnt=%b d_gnt=%b, want owner d=%b", if_gnt, d_gnt, e.d);
          end
          exp_q.delete(0);
          own_q.push_back(e.d);
          order_q.push_back(e.d);
        end
      end
    end
    if (!(m_req && m_gnt)) begin
      n_chk++;
      if ({if_gnt, d_gnt} !== 2'b00) begin
        n_fail++;
        $display("FAIL stray_gnt: got if_gnt=%b d_gnt=%b, want 00", if_gnt, d_gnt);
      end
    end
    if (m_rvalid) begin
      if (own_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rvalid: memory response with no transaction outstanding");
      end else begin
        o = own_q.pop_front();
        n_chk++;
        if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== {!o, o, o ? 32'h0 : m_rdata, o ? m_rdata : 32'h0}) begin
          n_fail++;
          $display("FAIL rvalid_route: got if_rv=%b d_rv=%b if_rdata=%h d_rdata=%h, want owner d=%b data=%h",
                   if_rvalid, d_rvalid, if_rdata, d_rdata, o, m_rdata);
        end
      end
    end else begin
      n_chk++;
      if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== 66'h0) begin
        n_fail++;
        $display("FAIL stray_rvalid: got if_rv=%b d_rv=%b if_rdata=%h d_rdata=%h, want all 0",
                 if_rvalid, d_rvalid, if_rdata, d_rdata);
      end
    end
    n_chk++;
    if (d_err !== 1'b0) begin
      n_fail++;
      $display("FAIL d_err_aligned: got %b want 0", d_err);
    end
  endtask

  task automatic drivers();
    txn_t t;
    if (!drv_en) return;
    if (if_req && if_gnt) if_req = 0;
    if (!if_req && if_q.size() != 0) begin
      t = if_q.pop_front();
      if_req = 1; if_addr = t.addr;
    end
    if (d_req && d_gnt) d_req = 0;
    if (!d_req && d_q.size() != 0) begin
      t = d_q.pop_front();
      d_req = 1; d_addr = t.addr; d_we = t.we; d_wdata = t.wdata; d_width = t.width;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1 mem_model();
    #1 monitor();
    #1 drivers();
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_we = 0; d_wdata = 0; d_width = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    if_q.delete(); d_q.delete(); exp_q.delete(); own_q.delete(); order_q.delete(); rdata_q.delete();
    drv_en = 0; mem_en = 0; mon_en = 0; rand_mode = 0;
    gdly = 0; rdly = 0; wcnt = 0; rcnt = 0; rpend = 0;
    repeat (2) step();
    rst = 0;
  endtask

  task automatic run_until_done(input int budget, input string name);
    for (int c = 0; c < budget && (exp_q.size() != 0 || own_q.size() != 0); c++) step();
    n_chk++;
    if (exp_q.size() != 0 || own_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d grants and %0d responses still outstanding, want 0", name, exp_q.size(), own_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1; if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h80; d_width = 2'b10;
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'hCAFEF00D;
    step(); step();
    n_chk++;
    if ({m_req, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mreq_busy: got m_req=%b busy=%b want 0 0", m_req, busy);
    end
    n_chk++;
    if ({m_addr, m_we, m_wdata, m_width} !== 67'h0) begin
      n_fail++; $display("FAIL reset_mfields: got addr=%h we=%b wdata=%h width=%b want 0", m_addr, m_we, m_wdata, m_width);
    end
    n_chk++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, d_err, if_rdata, d_rdata} !== 69'h0) begin
      n_fail++; $display("FAIL reset_strobes: got gnt=%b%b rv=%b%b err=%b rdata=%h/%h want 0",
                         if_gnt, d_gnt, if_rvalid, d_rvalid, d_err, if_rdata, d_rdata);
    end
  endtask

  task automatic test_idle_noise();
    do_reset();
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'h5A5A5A5A;
    step();
    n_chk++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, busy, m_req} !== 6'b0 || {if_rdata, d_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL idle_noise: got gnt=%b%b rv=%b%b busy=%b m_req=%b want all 0",
                         if_gnt, d_gnt, if_rvalid, d_rvalid, busy, m_req);
    end
  endtask

  task automatic test_single_load();
    do_reset();
    mem_en = 1; mon_en = 1;
    exp_q.push_back(mk(1, 32'h100, 0, 32'h0, 2'b10));
    rdata_q.push_back(32'hDEADBEEF);
    d_req = 1; d_addr = 32'h100; d_we = 0; d_wdata = 0; d_width = 2'b10;
    step();
    n_chk++;
    if ({m_req, d_gnt, if_gnt, m_we} !== 4'b1100 || m_addr !== 32'h100) begin
      n_fail++; $display("FAIL load_issue: got m_req=%b d_gnt=%b if_gnt=%b m_we=%b m_addr=%h want 1 1 0 0 00000100",
                         m_req, d_gnt, if_gnt, m_we, m_addr);
    end
    d_req = 0;
    step();
    n_chk++;
    if ({d_rvalid, if_rvalid} !== 2'b10 || d_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_resp: got d_rv=%b if_rv=%b d_rdata=%h want 1 0 deadbeef", d_rvalid, if_rvalid, d_rdata);
    end
    step();
    n_chk++;
    if ({busy, d_rvalid, m_req} !== 3'b000) begin
      n_fail++; $display("FAIL load_idle: got busy=%b d_rv=%b m_req=%b want 0 0 0", busy, d_rvalid, m_req);
    end
  endtask

  task automatic test_fetch_stream();
    int pulses = 0;
    bit started = 0, gap = 0;
    do_reset();
    if_q.push_back(mk(0, 32'h0, 0, 32'h0, 2'b10));
    if_q.push_back(mk(0, 32'h4, 0, 32'h0, 2'b10));
    if_q.push_back(mk(0, 32'h8, 0, 32'h0, 2'b10));
    build_order();
    mem_en = 1; mon_en = 1; drv_en = 1;
    for (int c = 0; c < 100 && pulses < 3; c++) begin
      step();
      if (busy === 1'b1) started = 1;
      else if (started) gap = 1;
      if (if_rvalid === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 3 || gap) begin
      n_fail++; $display("FAIL fetch_stream: got %0d if_rvalid pulses, idle gap=%b, want 3 and 0", pulses, gap);
    end
    n_chk++;
    if (order_q.size() != 3) begin
      n_fail++; $display("FAIL fetch_count: got %0d memory requests want 3", order_q.size());
    end
  endtask

  task automatic test_streak();
    logic [9:0] pat = 10'b1111011110;
    do_reset();
    for (int k = 0; k < 8; k++) d_q.push_back(mk(1, 32'h1000 + 32'(4 * k), 0, 32'h0, 2'b10));
    for (int k = 0; k < 2; k++) if_q.push_back(mk(0, 32'h40 + 32'(4 * k), 0, 32'h0, 2'b10));
    build_order();
    mem_en = 1; mon_en = 1; drv_en = 1;
    run_until_done(500, "streak");
    n_chk++;
    if (order_q.size() != 10) begin
      n_fail++; $display("FAIL streak_count: got %0d grants want 10", order_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        n_chk++;
        if (order_q[k] !== pat[9-k]) begin
          n_fail++; $display("FAIL streak_order[%0d]: got d=%b want d=%b", k, order_q[k], pat[9-k]);
        end
      end
    end
  endtask

  task automatic test_store_delay();
    do_reset();
    mem_en = 1; mon_en = 1; gdly = 3;
    exp_q.push_back(mk(1, 32'h20, 1, 32'h12345678, 2'b01));
    d_req = 1; d_addr = 32'h20; d_we = 1; d_wdata = 32'h12345678; d_width = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if ({m_req, m_we, m_width} !== 4'b1101 || m_addr !== 32'h20 || m_wdata !== 32'h12345678 || d_gnt !== (i == 3)) begin
        n_fail++; $display("FAIL store_hold[%0d]: got m_req=%b we=%b width=%b addr=%h wdata=%h d_gnt=%b want 1 1 01 20 12345678 %b",
                           i, m_req, m_we, m_width, m_addr, m_wdata, d_gnt, i == 3);
      end
    end
    d_req = 0;
    step();
    n_chk++;
    if ({d_rvalid, m_req} !== 2'b10) begin
      n_fail++; $display("FAIL store_ack: got d_rv=%b m_req=%b want 1 0", d_rvalid, m_req);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_en = 1; rdly = 2;
    d_req = 1; d_addr = 32'h200; d_we = 0; d_width = 2'b10;
    step();
    n_chk++;
    if ({m_req, d_gnt} !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_issue: got m_req=%b d_gnt=%b want 1 1", m_req, d_gnt);
    end
    d_req = 0;
    step();
    n_chk++;
    if ({busy, d_rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_wait: got busy=%b d_rv=%b want 1 0", busy, d_rvalid);
    end
    rst = 1;
    step();
    rst = 0;
    n_chk++;
    if ({busy, m_req} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_abort: got busy=%b m_req=%b want 0 0", busy, m_req);
    end
    step();
    n_chk++;
    if ({if_rvalid, d_rvalid, busy, m_req} !== 4'b0 || {if_rdata, d_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL rstmid_late_rvalid: got rv=%b%b busy=%b m_req=%b d_rdata=%h want all 0",
                         if_rvalid, d_rvalid, busy, m_req, d_rdata);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    mem_en = 1;
    @(posedge clk);
    #1 d_req = 1; d_addr = 32'h102; d_we = 1; d_wdata = 32'hA1B2C3D4; d_width = 2'b10;
`ifdef MEM_ARB_MISALIGN_EN
    #1;
    n_chk++;
    if ({d_gnt, m_req} !== 2'b10) begin
      n_fail++; $display("FAIL mis_gnt: got d_gnt=%b m_req=%b want 1 0", d_gnt, m_req);
    end
    @(posedge clk);
    #1 d_req = 0;
    step();
    n_chk++;
    if ({d_rvalid, d_err, m_req, d_gnt} !== 4'b1100) begin
      n_fail++; $display("FAIL mis_err: got d_rv=%b d_err=%b m_req=%b d_gnt=%b want 1 1 0 0", d_rvalid, d_err, m_req, d_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({d_rvalid, d_err, m_req, busy} !== 4'b0) begin
        n_fail++; $display("FAIL mis_after[%0d]: got d_rv=%b d_err=%b m_req=%b busy=%b want 0", i, d_rvalid, d_err, m_req, busy);
      end
    end
`else
    step();
    step();
    n_chk++;
    if ({m_req, d_gnt, m_we} !== 3'b111 || m_addr !== 32'h102) begin
      n_fail++; $display("FAIL mis_forward: got m_req=%b d_gnt=%b m_we=%b m_addr=%h want 1 1 1 00000102", m_req, d_gnt, m_we, m_addr);
    end
    d_req = 0;
    step();
    n_chk++;
    if ({d_rvalid, d_err} !== 2'b10) begin
      n_fail++; $display("FAIL mis_ack: got d_rv=%b d_err=%b want 1 0", d_rvalid, d_err);
    end
`endif
  endtask

  task automatic test_random();
    int n_if, n_d, n_exp;
    logic [31:0] a;
    logic [1:0] w;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n_if = $urandom_range(2, 12);
      n_d = $urandom_range(2, 14);
      for (int k = 0; k < n_if; k++) begin
        a = $urandom(); a[1:0] = 2'b00;
        if_q.push_back(mk(0, a, 0, 32'h0, 2'b10));
      end
      for (int k = 0; k < n_d; k++) begin
        w = 2'($urandom_range(0, 2));
        a = $urandom();
        if (w == 2'b10) a[1:0] = 2'b00;
        else if (w == 2'b01) a[0] = 1'b0;
        d_q.push_back(mk(1, a, 1'($urandom_range(0, 1)), $urandom(), w));
      end
      build_order();
      n_exp = exp_q.size();
      mem_en = 1; rand_mode = 1; mon_en = 1; drv_en = 1;
      gdly = $urandom_range(0, 3); rdly = $urandom_range(0, 2);
      run_until_done(3000, "random");
      n_chk++;
      if (order_q.size() != n_exp) begin
        n_fail++; $display("FAIL random_count[%0d]: got %0d grants want %0d", r, order_q.size(), n_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_noise();
    test_single_load();
    test_fetch_stream();
    test_streak();
    test_store_delay();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the load/store unit (D).
- Sits between the fetch stage, the LSU and the memory bus.
- Allows one outstanding transaction at a time.
- Data requests have priority over fetch, with a streak limit so fetch cannot starve.

Parameters:
- MAX_DSTREAK, 4: consecutive D grants allowed while IF is waiting before IF is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch address (word aligned)
- if_gnt  out  1  fetch request accepted by memory
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetch data
- d_req  in  1  data request; held with its fields until d_gnt
- d_addr  in  32  data address
- d_we  in  1  1 = store
- d_wdata  in  32  store data
- d_width  in  2  00 = byte, 01 = half, 10 = word
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  one-cycle pulse: load data or store ack
- d_rdata  out  32  load data
- d_err  out  1  qualified by d_rvalid; misaligned access (see Optional Feature)
- m_req  out  1  memory request
- m_addr  out  32  memory address
- m_we  out  1  memory write enable
- m_wdata  out  32  memory write data
- m_width  out  2  memory access width
- m_gnt  in  1  memory accepts the request in the cycle where m_req & m_gnt
- m_rvalid  in  1  response; returned for both reads and writes
- m_rdata  in  32  read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, owner = IF, streak counter = 0.
- A reset in the middle of a transaction abandons it: m_req drops at the next edge, and an m_rvalid arriving afterwards in IDLE is ignored.
- States:
  - IDLE: if neither request is pending, stay.
    - Otherwise pick the winner, register m_addr/m_we/m_wdata/m_width from the winner, set m_req = 1 and go to WAIT_GNT.
    - For an IF winner, m_we = 0 and m_width = 10.
  - WAIT_GNT: hold m_req and all m_* fields stable.
    - On m_gnt: pulse the owner's gnt combinationally that cycle (if_gnt = m_gnt & WAIT_GNT & owner == IF, likewise d_gnt).
    - Registered m_req drops the next cycle; go to WAIT_RESP.
  - WAIT_RESP: on m_rvalid, pass m_rdata to the owner's rdata and pulse the owner's rvalid in the same cycle (combinational).
    - The same edge re-arbitrates: if a request is pending, go straight to WAIT_GNT with new fields; otherwise go to IDLE.
- Arbitration:
  - D wins if d_req, unless IF is also requesting and the streak counter equals MAX_DSTREAK.
  - The streak counter increments on each D win while if_req = 1.
  - It clears on any IF win, or on a D win with if_req = 0.
  - It saturates at MAX_DSTREAK.
- Latency: request seen at cycle N → m_req at N+1. With m_gnt at N+1 and m_rvalid at N+2, the owner's rvalid is at N+2.
- Both requests in the same cycle: D wins, unless the streak limit has been reached.
- Requesters may assert a new req in the cycle after their gnt.
- Idle gaps: m_rvalid in IDLE or WAIT_GNT is ignored, and m_gnt outside WAIT_GNT is ignored.
- if_rdata/d_rdata hold m_rdata only when valid and are 0 otherwise.

Optional Feature:
- Macro: MEM_ARB_MISALIGN_EN.
- Defined: a D request that is misaligned (half with addr[0] = 1, word with addr[1:0] != 0) is never sent to memory.
  - In IDLE the arbiter enters ERR: d_gnt pulses that cycle and d_rvalid & d_err pulse the next cycle, then it returns to IDLE.
  - Misaligned requests count toward the streak counter.
- Not defined: d_err is tied 0 and misaligned requests are forwarded unchanged.

Test Plan:
- Single load, d_addr = 0x100, d_width = 10; memory gnt at once, m_rvalid one cycle later with 0xDEADBEEF → m_req one cycle after d_req, m_addr = 0x100, m_we = 0, d_rvalid pulse with d_rdata = 0xDEADBEEF, if_rvalid stays 0.
- Fetch-only stream at 0x0, 0x4, 0x8 → three m_req with matching addresses, m_width = 10, three if_rvalid pulses, and no IDLE cycle between back-to-back requests.
- if_req and d_req held high continuously with MAX_DSTREAK = 4 → grant order D, D, D, D, IF, D, D, D, D, IF.
- Store d_addr = 0x20, d_wdata = 0x12345678, d_width = 01; m_gnt delayed 3 cycles → m_req and all fields stable for all 4 cycles, d_gnt only in the final one, d_rvalid on the ack.
- Assert rst during WAIT_RESP, then m_rvalid arrives → no rvalid to either requester, busy = 0 and m_req = 0 after the reset edge.
- With MEM_ARB_MISALIGN_EN: word store at 0x102 → m_req never rises, d_gnt pulses and then d_rvalid = 1 with d_err = 1. Without the macro: the request is forwarded with m_addr = 0x102 and d_err = 0.
